// File: rtl/sos_pkg.sv
// rtl/sos_pkg.sv - shared constants, coefficient index and FSM state types for the SOS coefficient loader
package sos_pkg;

    localparam logic signed [15:0] Q14_ONE      = 16'sh4000;
    localparam int                 COEF_PER_SEC = 5;

    typedef enum logic [2:0] {
        B0 = 3'd0,
        B1 = 3'd1,
        B2 = 3'd2,
        A1 = 3'd3,
        A2 = 3'd4
    } coef_idx_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        PEND  = 2'd3
    } state_e;

endpackage

// File: rtl/sos_stab_check.sv
// rtl/sos_stab_check.sv - combinational stability-triangle test for one section's a1/a2
module sos_stab_check
    import sos_pkg::*;
#(
    parameter int COEF_W = 16
) (
    input  logic [COEF_W-1:0] a1_i,
    input  logic [COEF_W-1:0] a2_i,
    output logic              stable_o
);

    localparam int EXT = 18 - COEF_W;

    logic signed [17:0] a1_x;
    logic signed [17:0] a2_x;
    logic signed [17:0] a1_abs;
    logic signed [17:0] a2_abs;
    logic signed [17:0] one_x;

    // Widen to 18 bits so |-2.0| and 1.0 + a2 never overflow, then test |a2| < 1 and |a1| < 1 + a2
    always_comb begin
        a1_x     = {{EXT{a1_i[COEF_W-1]}}, a1_i};
        a2_x     = {{EXT{a2_i[COEF_W-1]}}, a2_i};
        one_x    = {{2{Q14_ONE[15]}}, Q14_ONE};
        a1_abs   = a1_x[17] ? -a1_x : a1_x;
        a2_abs   = a2_x[17] ? -a2_x : a2_x;
        stable_o = (a2_abs < one_x) && (a1_abs < (one_x + a2_x));
    end

endmodule

// File: rtl/sos_coef_loader.sv
// rtl/sos_coef_loader.sv - shadow/active coefficient bank loader for the SOS cascade; optional COEF_STAB_CHECK_EN
module sos_coef_loader
    import sos_pkg::*;
#(
    parameter int NUM_SEC = 4,
    parameter int COEF_W  = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    input  logic [COEF_W-1:0]                     s_data,
    input  logic                                  s_last,
    input  logic                                  sample_tick,
    output logic [NUM_SEC*COEF_PER_SEC*COEF_W-1:0] coef_flat,
    output logic                                  load_done,
    output logic                                  load_err
);

    localparam int                N     = NUM_SEC * COEF_PER_SEC;
    localparam int                CNT_W = $clog2(N);
    localparam logic [COEF_W-1:0] ONE   = COEF_W'(Q14_ONE);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              s_ready_q;
    logic              load_done_q;
    logic              load_err_q;
    logic [COEF_W-1:0] shadow_q [N];
    logic [COEF_W-1:0] active_q [N];

    logic              accept;
    logic [CNT_W-1:0]  wr_idx;
    logic              at_end;
    logic              swap;

`ifdef COEF_STAB_CHECK_EN
    localparam int CHK_W = (NUM_SEC > 1) ? $clog2(NUM_SEC) : 1;

    logic [CHK_W-1:0]  chk_q;
    logic              fail_q;
    logic [COEF_W-1:0] sec_a1;
    logic [COEF_W-1:0] sec_a2;
    logic              sec_stable;

    // Select the a1/a2 pair of the section being checked this cycle
    always_comb begin
        sec_a1 = '0;
        sec_a2 = '0;
        for (int k = 0; k < NUM_SEC; k++) begin
            if (chk_q == CHK_W'(k)) begin
                sec_a1 = shadow_q[k*COEF_PER_SEC + int'(A1)];
                sec_a2 = shadow_q[k*COEF_PER_SEC + int'(A2)];
            end
        end
    end

    sos_stab_check #(.COEF_W(COEF_W)) u_stab (
        .a1_i     (sec_a1),
        .a2_i     (sec_a2),
        .stable_o (sec_stable)
    );
`endif

    // Handshake decode: the first word of a load always lands in slot 0
    always_comb begin
        accept = s_valid && s_ready_q;
        wr_idx = (state_q == LOAD) ? cnt_q : '0;
        at_end = (wr_idx == CNT_W'(N - 1));
        swap   = (state_q == PEND) && sample_tick;
    end

    // Control FSM with registered ready and one-cycle status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            s_ready_q   <= 1'b0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
`ifdef COEF_STAB_CHECK_EN
            chk_q       <= '0;
            fail_q      <= 1'b0;
`endif
        end else begin
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
            case (state_q)
                IDLE, LOAD: begin
                    s_ready_q <= 1'b1;
                    if (accept) begin
                        if (at_end && s_last) begin
                            s_ready_q <= 1'b0;
`ifdef COEF_STAB_CHECK_EN
                            state_q   <= CHECK;
                            chk_q     <= '0;
                            fail_q    <= 1'b0;
`else
                            state_q   <= PEND;
`endif
                        end else if (at_end || s_last) begin
                            load_err_q <= 1'b1;
                            state_q    <= IDLE;
                        end else begin
                            state_q <= LOAD;
                            cnt_q   <= wr_idx + CNT_W'(1);
                        end
                    end
                end
                CHECK: begin
`ifdef COEF_STAB_CHECK_EN
                    // One section per cycle; the verdict is taken after the last section
                    fail_q <= fail_q | ~sec_stable;
                    if (chk_q == CHK_W'(NUM_SEC - 1)) begin
                        if (fail_q || !sec_stable) begin
                            load_err_q <= 1'b1;
                            state_q    <= IDLE;
                            s_ready_q  <= 1'b1;
                        end else begin
                            state_q <= PEND;
                        end
                    end else begin
                        chk_q <= chk_q + CHK_W'(1);
                    end
`else
                    state_q   <= IDLE;
                    s_ready_q <= 1'b1;
`endif
                end
                PEND: begin
                    if (sample_tick) begin
                        state_q     <= IDLE;
                        s_ready_q   <= 1'b1;
                        load_done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    s_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Shadow capture on accepted words; whole-bank swap into active at the sample boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                shadow_q[i] <= (i % COEF_PER_SEC == int'(B0)) ? ONE : '0;
                active_q[i] <= (i % COEF_PER_SEC == int'(B0)) ? ONE : '0;
            end
        end else begin
            if (accept) begin
                shadow_q[wr_idx] <= s_data;
            end
            if (swap) begin
                active_q <= shadow_q;
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_flat
        assign coef_flat[g*COEF_W +: COEF_W] = active_q[g];
    end

    assign s_ready   = s_ready_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;

endmodule
